// File: rtl/stone_ram_arbiter_if.sv
// Bus bundle between the stone RAM arbiter, its three requesters and the RAM.
// Renderer: draw_req/draw_addr in, draw_ack out.
// Ropes 0/1: req/op/addr/wdata in, ack/ok out.
// Shared outputs: rdata, busy.
// RAM side: ram_address/ram_data/ram_wren out, ram_q in.
// The slave modport is the arbiter. The master modport is the requesters plus the RAM model.
interface stone_ram_arbiter_if;
  logic        draw_req;
  logic [3:0]  draw_addr;
  logic        draw_ack;
  logic        rope0_req;
  logic [1:0]  rope0_op;
  logic [3:0]  rope0_addr;
  logic [31:0] rope0_wdata;
  logic        rope0_ack;
  logic        rope0_ok;
  logic        rope1_req;
  logic [1:0]  rope1_op;
  logic [3:0]  rope1_addr;
  logic [31:0] rope1_wdata;
  logic        rope1_ack;
  logic        rope1_ok;
  logic [31:0] rdata;
  logic [3:0]  ram_address;
  logic [31:0] ram_data;
  logic        ram_wren;
  logic [31:0] ram_q;
  logic        busy;

  modport slave (
    input  draw_req, draw_addr,
    input  rope0_req, rope0_op, rope0_addr, rope0_wdata,
    input  rope1_req, rope1_op, rope1_addr, rope1_wdata,
    input  ram_q,
    output draw_ack, rope0_ack, rope0_ok, rope1_ack, rope1_ok,
    output rdata, ram_address, ram_data, ram_wren, busy
  );

  modport master (
    output draw_req, draw_addr,
    output rope0_req, rope0_op, rope0_addr, rope0_wdata,
    output rope1_req, rope1_op, rope1_addr, rope1_wdata,
    output ram_q,
    input  draw_ack, rope0_ack, rope0_ok, rope1_ack, rope1_ok,
    input  rdata, ram_address, ram_data, ram_wren, busy
  );
endinterface

// File: rtl/stone_ram_arbiter.sv
// Owner of the 16-entry stone RAM.
// Serialises renderer reads and rope read/write/claim/release commands onto the single RAM port.
// Claim (test-and-set of bit 0) and release (clear bits 1:0) are atomic read-modify-write sequences.
// Ports:
//   clock_i - system clock.
//   reset_i - synchronous, active-high reset.
//   bus     - requester and RAM signals; see stone_ram_arbiter_if.
module stone_ram_arbiter #(
  parameter int unsigned RAM_LAT    = 1,
  parameter int unsigned DRAW_BURST = 8
) (
  input  logic                clock_i,
  input  logic                reset_i,
  stone_ram_arbiter_if.slave  bus
);
  localparam int unsigned BW = $clog2(DRAW_BURST + 1);
  localparam int unsigned LW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

  localparam logic [1:0] OP_RD    = 2'd0;
  localparam logic [1:0] OP_WR    = 2'd1;
  localparam logic [1:0] OP_CLAIM = 2'd2;

  typedef enum logic [2:0] {IDLE, ISSUE_RD, WAIT_RD, MODIFY, ISSUE_WR, ACK} state_e;

  typedef struct packed {
    logic [1:0]  op;
    logic [3:0]  addr;
    logic [31:0] wdata;
  } slot_t;

  // Requester index 0 = renderer, 1 = rope0, 2 = rope1.
  state_e        state_q, state_d;
  slot_t [2:0]   slot_q, slot_d;
  logic  [2:0]   pend_q, pend_d;
  logic  [1:0]   win_q, win_d;
  logic          last_rope_q, last_rope_d;
  logic  [BW-1:0] burst_q, burst_d;
  logic  [LW-1:0] lat_q, lat_d;
  logic  [31:0]  cap_q, cap_d;
  logic          res_ok_q, res_ok_d;
  logic  [3:0]   addr_q, addr_d;
  logic  [31:0]  data_q, data_d;
  logic          wren_q, wren_d;
  logic  [2:0]   ack_q, ack_d;
  logic  [1:0]   ok_q, ok_d;
  logic  [31:0]  rdata_q, rdata_d;
  logic          busy_q, busy_d;

  logic  [2:0]   req_c;
  slot_t [2:0]   in_c;

  assign req_c = {bus.rope1_req, bus.rope0_req, bus.draw_req};
  assign in_c[0] = {OP_RD, bus.draw_addr, 32'd0};
  assign in_c[1] = {bus.rope0_op, bus.rope0_addr, bus.rope0_wdata};
  assign in_c[2] = {bus.rope1_op, bus.rope1_addr, bus.rope1_wdata};

  // State and output registers.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      slot_q      <= '0;
      pend_q      <= '0;
      win_q       <= '0;
      last_rope_q <= 1'b1;
      burst_q     <= '0;
      lat_q       <= '0;
      cap_q       <= '0;
      res_ok_q    <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      wren_q      <= 1'b0;
      ack_q       <= '0;
      ok_q        <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      pend_q      <= pend_d;
      win_q       <= win_d;
      last_rope_q <= last_rope_d;
      burst_q     <= burst_d;
      lat_q       <= lat_d;
      cap_q       <= cap_d;
      res_ok_q    <= res_ok_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      wren_q      <= wren_d;
      ack_q       <= ack_d;
      ok_q        <= ok_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
    end
  end

  // Slot capture, grant arbitration and command sequencing.
  always_comb begin
    logic  [1:0] gnt;
    logic        rope;
    logic        any_rope;
    logic        ok_v;
    slot_t       sel;
    state_d     = state_q;
    slot_d      = slot_q;
    pend_d      = pend_q;
    win_d       = win_q;
    last_rope_d = last_rope_q;
    burst_d     = burst_q;
    lat_d       = lat_q;
    cap_d       = cap_q;
    res_ok_d    = res_ok_q;
    addr_d      = addr_q;
    data_d      = data_q;
    wren_d      = 1'b0;
    ack_d       = '0;
    rdata_d     = rdata_q;
    gnt         = 2'd0;
    rope        = 1'b0;
    ok_v        = 1'b1;
    any_rope    = pend_q[1] | pend_q[2];
    sel         = slot_q[win_q];

    case (state_q)
      IDLE: begin
        if (|pend_q) begin
          if (pend_q[0] && !(burst_q == BW'(DRAW_BURST) && any_rope)) begin
            gnt = 2'd0;
            if (any_rope) burst_d = BW'(burst_q + 1'b1);
          end else begin
            rope        = (pend_q[1] && pend_q[2]) ? ~last_rope_q : pend_q[2];
            gnt         = rope ? 2'd2 : 2'd1;
            last_rope_d = rope;
            burst_d     = '0;
          end
          win_d    = gnt;
          sel      = slot_q[gnt];
          addr_d   = sel.addr;
          res_ok_d = 1'b1;
          if (sel.op == OP_WR) begin
            data_d  = sel.wdata;
            wren_d  = 1'b1;
            state_d = ISSUE_WR;
          end else begin
            state_d = ISSUE_RD;
          end
        end
      end
      ISSUE_RD: begin
        lat_d   = '0;
        state_d = WAIT_RD;
      end
      WAIT_RD: begin
        if (lat_q == LW'(RAM_LAT - 1)) begin
          cap_d = bus.ram_q;
          if (sel.op == OP_RD) begin
            rdata_d      = bus.ram_q;
            ack_d[win_q] = 1'b1;
            state_d      = ACK;
          end else begin
            state_d = MODIFY;
          end
        end else begin
          lat_d = LW'(lat_q + 1'b1);
        end
      end
      MODIFY: begin
        // Claim succeeds only on a visible, not-yet-moving stone.
        if (sel.op == OP_CLAIM) begin
          if (cap_q[1] & ~cap_q[0]) begin
            data_d  = cap_q | 32'd1;
            wren_d  = 1'b1;
            state_d = ISSUE_WR;
          end else begin
            ok_v         = 1'b0;
            rdata_d      = cap_q;
            ack_d[win_q] = 1'b1;
            state_d      = ACK;
          end
        end else begin
          data_d  = cap_q & ~32'h3;
          wren_d  = 1'b1;
          state_d = ISSUE_WR;
        end
      end
      ISSUE_WR: begin
        ok_v = res_ok_q;
        if (sel.op != OP_WR) rdata_d = cap_q;
        ack_d[win_q] = 1'b1;
        state_d      = ACK;
      end
      ACK: begin
        pend_d[win_q] = 1'b0;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A request in its own ack cycle is accepted: set wins over clear.
    for (int i = 0; i < 3; i++) begin
      if (req_c[i] && (!pend_q[i] || (state_q == ACK && win_q == 2'(i)))) begin
        slot_d[i] = in_c[i];
        pend_d[i] = 1'b1;
      end
    end

    ok_d   = {ack_d[2] & ok_v, ack_d[1] & ok_v};
    busy_d = (state_d != IDLE);
  end

  assign bus.draw_ack    = ack_q[0];
  assign bus.rope0_ack   = ack_q[1];
  assign bus.rope1_ack   = ack_q[2];
  assign bus.rope0_ok    = ok_q[0];
  assign bus.rope1_ok    = ok_q[1];
  assign bus.rdata       = rdata_q;
  assign bus.ram_address = addr_q;
  assign bus.ram_data    = data_q;
  // Gated by reset so a reset landing on ISSUE_WR never writes.
  assign bus.ram_wren    = wren_q & ~reset_i;
  assign bus.busy        = busy_q;
endmodule
